// File: rtl/nios_pio_pkg.sv
// Shared constants for the player input PIO: register map, edge modes, bus width.
// Pure declarations, no logic, no latency, no flow control.
package nios_pio_pkg;

    localparam int RDATA_W = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE    = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_pio_debounce.sv
// Single-channel debouncer: stable follows sync after DB_CYCLES consecutive differing samples.
// Latency DB_CYCLES cycles; no flow control, runs every cycle.
module nios_pio_debounce #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sync,
    output logic o_stable
);

    localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    // Any sample that agrees with the current level restarts the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (i_sync == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt    <= '0;
            r_stable <= i_sync;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/nios_player_pio.sv
// Avalon-MM player input PIO: 2-flop sync, edge capture (W1C), irq mask, level irq; 1-cycle read.
// Pin-to-data 2 cycles (2+DB_CYCLES with NIOS_PLAYER_PIO_DEBOUNCE_EN); slave never stalls.
module nios_player_pio
    import nios_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0,
    parameter int DB_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    input  logic [WIDTH-1:0]   in_port,
    output logic               irq
);

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_prev;
    logic [WIDTH-1:0]   r_edge_cap;
    logic [WIDTH-1:0]   r_irq_mask;
    logic [1:0]         r_arm;
    logic [RDATA_W-1:0] r_readdata;

    logic [WIDTH-1:0]   w_stable;
    logic [WIDTH-1:0]   w_edge;
    logic [WIDTH-1:0]   w_clear;
    logic [WIDTH-1:0]   w_edge_cap_nxt;
    logic [RDATA_W-1:0] w_rdata;
    logic               w_wr;
    logic               w_armed;
    logic               w_unused_wdata;

    assign w_unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef NIOS_PLAYER_PIO_DEBOUNCE_EN
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
        nios_pio_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_sync   (r_sync2[gi]),
            .o_stable (w_stable[gi])
        );
    end
`else
    localparam int DB_UNUSED_CYCLES = DB_CYCLES;
    assign w_stable = r_sync2;
`endif

    // Inputs already asserted at reset release would look like edges; hold off for 3 cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arm  <= '0;
            r_prev <= '0;
        end else begin
            r_prev <= w_stable;
            if (r_arm != 2'd3) begin
                r_arm <= r_arm + 2'd1;
            end
        end
    end

    assign w_armed = (r_arm == 2'd3);

    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            EDGE_FALLING: w_edge = ~w_stable & r_prev;
            EDGE_ANY:     w_edge = w_stable ^ r_prev;
            default:      w_edge = w_stable & ~r_prev;
        endcase
        if (!w_armed) begin
            w_edge = '0;
        end
    end

    assign w_wr           = chipselect & ~write_n;
    assign w_clear        = (w_wr && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
    // A new edge in the same cycle as its clear keeps the bit set.
    assign w_edge_cap_nxt = (r_edge_cap & ~w_clear) | w_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
            r_irq_mask <= '0;
        end else begin
            r_edge_cap <= w_edge_cap_nxt;
            if (w_wr && (address == ADDR_IRQMASK)) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:    w_rdata[WIDTH-1:0] = w_stable;
            ADDR_RSVD:    w_rdata            = '0;
            ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE:    w_rdata[WIDTH-1:0] = r_edge_cap;
            default:      w_rdata            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_nios_player_pio.sv
// Bench for nios_player_pio: three instances (rising/falling/any) share one stimulus stream
// and are checked every cycle against a pin-history model plus directed literal checks.
`timescale 1ns/1ps
module tb_nios_player_pio;

    localparam int W  = 8;
    localparam int DB = 4;
`ifdef NIOS_PLAYER_PIO_DEBOUNCE_EN
    localparam int LAT  = 2 + DB;
    localparam bit DBEN = 1'b1;
`else
    localparam int LAT  = 2;
    localparam bit DBEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [W-1:0] in_port = 8'hFF;
    logic [31:0]  rd_dut [3];
    logic         irq_dut [3];

    int tests = 0;
    int errs  = 0;

    always #5 clk = ~clk;

    nios_player_pio #(.WIDTH(W), .EDGE_TYPE(0), .DB_CYCLES(DB)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_dut[0]),
        .in_port(in_port), .irq(irq_dut[0]));
    nios_player_pio #(.WIDTH(W), .EDGE_TYPE(1), .DB_CYCLES(DB)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_dut[1]),
        .in_port(in_port), .irq(irq_dut[1]));
    nios_player_pio #(.WIDTH(W), .EDGE_TYPE(2), .DB_CYCLES(DB)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_dut[2]),
        .in_port(in_port), .irq(irq_dut[2]));

    // Model: n = clock edges since reset release; pinh[k] = pin seen at edge k+1;
    // sync after n edges = pin two edges earlier; stab[n] = value software sees after n edges.
    int           n;
    logic [W-1:0] pinh [4096];
    logic [W-1:0] stab [4096];
    logic [W-1:0] m_cap [3];
    logic [W-1:0] m_mask;
    logic [31:0]  m_rd [3];

    function automatic logic [W-1:0] sync_at(input int k);
        return (k >= 2) ? pinh[(k - 2) & 4095] : '0;
    endfunction

    function automatic logic [W-1:0] stab_at(input int k);
        return (k >= 0) ? stab[k & 4095] : '0;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model_step
        logic [W-1:0] cur, prv, ev, clr, sn, s;
        bit           held;
        if (!reset_n) begin
            n       = 0;
            stab[0] = '0;
            m_mask  = '0;
            for (int e = 0; e < 3; e++) begin
                m_cap[e] = '0;
                m_rd[e]  = '0;
            end
        end else begin
            cur = stab_at(n);
            prv = stab_at(n - 1);
            for (int e = 0; e < 3; e++) begin
                case (address)
                    2'd0:    m_rd[e] = {{(32-W){1'b0}}, cur};
                    2'd2:    m_rd[e] = {{(32-W){1'b0}}, m_mask};
                    2'd3:    m_rd[e] = {{(32-W){1'b0}}, m_cap[e]};
                    default: m_rd[e] = '0;
                endcase
            end
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            for (int e = 0; e < 3; e++) begin
                if (n < 3)       ev = '0;
                else if (e == 0) ev = cur & ~prv;
                else if (e == 1) ev = ~cur & prv;
                else             ev = cur ^ prv;
                m_cap[e] = (m_cap[e] & ~clr) | ev;
            end
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            pinh[n & 4095] = in_port;
            n = n + 1;
            if (!DBEN) begin
                sn = sync_at(n);
            end else begin
                // A bit moves only after DB consecutive samples all disagreeing with it.
                sn = cur;
                for (int b = 0; b < W; b++) begin
                    held = 1'b1;
                    for (int j = 1; j <= DB; j++) begin
                        s = sync_at(n - j);
                        if (s[b] == cur[b]) held = 1'b0;
                    end
                    if (held) begin
                        s = sync_at(n - 1);
                        sn[b] = s[b];
                    end
                end
            end
            stab[n & 4095] = sn;
        end
    end

    always @(negedge clk) begin
        for (int e = 0; e < 3; e++) begin
            tests++;
            if (rd_dut[e] !== m_rd[e]) begin
                errs++;
                $display("FAIL cmp_readdata[%0d] t=%0t got 0x%08h expected 0x%08h", e, $time, rd_dut[e], m_rd[e]);
            end
            tests++;
            if (irq_dut[e] !== (|(m_cap[e] & m_mask))) begin
                errs++;
                $display("FAIL cmp_irq[%0d] t=%0t got %b expected %b", e, $time, irq_dut[e], |(m_cap[e] & m_mask));
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick(1);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_readdata", rd_dut[0], 32'h0);
        chk("reset_irq", {31'b0, irq_dut[2]}, 32'h0);

        // Arm guard: pins high through reset release.
        reset_n = 1'b1;
        tick(LAT + 6);
        rd(2'd3);
        chk("arm_cap_rise", rd_dut[0], DBEN ? 32'hFF : 32'h00);
        chk("arm_cap_fall", rd_dut[1], 32'h00);
        chk("arm_irq", {31'b0, irq_dut[0]}, 32'h0);
        chk("model_arm_cap_any", {24'b0, m_cap[2]}, DBEN ? 32'hFF : 32'h00);

        // Data read and reserved address.
        in_port = 8'hA5;
        tick(LAT + 3);
        rd(2'd0);
        chk("data_read", rd_dut[0], 32'h000000A5);
        rd(2'd1);
        chk("rsvd_read", rd_dut[2], 32'h0);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd3);
        chk("fall_cap_5a", rd_dut[1], 32'h5A);
        chk("any_cap_5a", rd_dut[2], DBEN ? 32'hFF : 32'h5A);
        wr(2'd3, 32'hFF);
        in_port = 8'h00;
        tick(LAT + 3);
        wr(2'd3, 32'hFF);
        rd(2'd3);
        chk("cap_cleared", rd_dut[1], 32'h0);

        // Rising capture, irq timing, W1C.
        wr(2'd2, 32'h01);
        in_port = 8'h01;
        tick(LAT);
        chk("rise_irq_early", {31'b0, irq_dut[0]}, 32'h0);
        tick(1);
        chk("rise_irq", {31'b0, irq_dut[0]}, 32'h1);
        chk("any_irq", {31'b0, irq_dut[2]}, 32'h1);
        chk("fall_irq", {31'b0, irq_dut[1]}, 32'h0);
        rd(2'd3);
        chk("rise_cap", rd_dut[0], 32'h01);
        wr(2'd3, 32'h01);
        chk("rise_irq_cleared", {31'b0, irq_dut[0]}, 32'h0);

        // Set beats clear in the capture cycle.
        in_port = 8'h05;
        tick(LAT);
        wr(2'd3, 32'h04);
        rd(2'd3);
        chk("collide_any", rd_dut[2], 32'h04);
        chk("collide_rise", rd_dut[0], 32'h04);
        wr(2'd3, 32'h01);
        rd(2'd3);
        chk("w1c_keep_other", rd_dut[2], 32'h04);
        wr(2'd3, 32'h04);
        rd(2'd3);
        chk("w1c_clear", rd_dut[2], 32'h00);

        // Mask gating.
        wr(2'd2, 32'h0F);
        in_port = 8'h35;
        tick(LAT + 2);
        rd(2'd3);
        chk("mask_cap", rd_dut[0], 32'h30);
        chk("mask_irq_off", {31'b0, irq_dut[0]}, 32'h0);
        wr(2'd2, 32'h10);
        chk("mask_irq_on", {31'b0, irq_dut[0]}, 32'h1);
        rd(2'd2);
        chk("mask_read", rd_dut[1], 32'h10);

        // Reset mid-operation.
        reset_n = 1'b0;
        #1;
        chk("midrst_irq", {31'b0, irq_dut[0]}, 32'h0);
        chk("midrst_rd", rd_dut[1], 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(LAT + 6);
        rd(2'd3);
        chk("midrst_arm_rise", rd_dut[0], DBEN ? 32'h35 : 32'h00);
        rd(2'd2);
        chk("midrst_mask", rd_dut[2], 32'h0);

`ifdef NIOS_PLAYER_PIO_DEBOUNCE_EN
        wr(2'd3, 32'hFF);
        in_port = 8'h37;
        tick(3);
        in_port = 8'h35;
        tick(DB + 6);
        rd(2'd0);
        chk("db_short_data", rd_dut[0], 32'h35);
        rd(2'd3);
        chk("db_short_cap", rd_dut[2], 32'h00);
        address = 2'd0;
        in_port = 8'h37;
        tick(LAT);
        chk("db_long_data_early", rd_dut[0], 32'h35);
        in_port = 8'h35;
        tick(1);
        chk("db_long_data", rd_dut[0], 32'h37);
        tick(1);
        rd(2'd3);
        chk("db_long_cap", rd_dut[0], 32'h02);
        tick(DB + 4);
`endif

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #200000;
        errs++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
